alu_seq: RTL

- Registered, parametrised ALU for the datapath.
- Handshaked input and output stages: valid/ready on both sides.
- Single-cycle ops: add, sub, logic, shift.
- Multi-cycle shift-add multiply with a double-width product.
- Output register holds its result until the consumer accepts it, so upstream stalls cleanly.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Handshake/operand bundle for alu_seq: producer-side valid/ready with operands,
// consumer-side valid/ready with result and flags.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result_Hi;
    logic             Zero;
    logic             Carry;
    logic             Overflow;
    logic             Negative;

    modport master (
        output in_valid, A, B, ALU_Sel, out_ready,
        input  in_ready, out_valid, Result, Result_Hi, Zero, Carry, Overflow, Negative
    );

    modport slave (
        input  in_valid, A, B, ALU_Sel, out_ready,
        output in_ready, out_valid, Result, Result_Hi, Zero, Carry, Overflow, Negative
    );
endinterface

// File: rtl/alu_seq.sv
// Registered handshaked ALU with single-cycle ops and a shift-add multiplier.
// Define ALU_SEQ_FLAGS_EN to build Carry/Overflow/Negative logic; otherwise they are tied 0.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic     clk,
    input logic     rst,
    alu_seq_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    logic [0:0]         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept;
    logic               consume;
    logic [2*WIDTH-1:0] acc_step;
    logic [CNT_W-1:0]   count_step;
    logic [WIDTH-1:0]   alu_res;
`ifdef ALU_SEQ_FLAGS_EN
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               alu_carry;
    logic               alu_ovf;
`endif

    // A new op may enter only when idle and the output slot is free or draining this edge.
    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_q && bus.out_ready;

    assign acc_step   = mplier_q[0] ? acc_q + (mcand_q << count_q) : acc_q;
    assign count_step = count_q + CNT_W'(1);

    always_comb begin
        alu_res = '0;
`ifdef ALU_SEQ_FLAGS_EN
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
`endif
        case (bus.ALU_Sel)
`ifdef ALU_SEQ_FLAGS_EN
            OP_ADD: begin
                {alu_carry, alu_res} = {1'b0, bus.A} + {1'b0, bus.B};
                alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                {alu_carry, alu_res} = {1'b0, bus.A} - {1'b0, bus.B};
                alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SHL: {alu_carry, alu_res} = {1'b0, bus.A} << bus.B;
            OP_SHR: {alu_res, alu_carry} = {bus.A, 1'b0} >> bus.B;
`else
            OP_ADD: alu_res = bus.A + bus.B;
            OP_SUB: alu_res = bus.A - bus.B;
            OP_SHL: alu_res = bus.A << bus.B;
            OP_SHR: alu_res = bus.A >> bus.B;
`endif
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_NOT: alu_res = ~bus.A;
            OP_XOR: alu_res = bus.A ^ bus.B;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block infers a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
`ifdef ALU_SEQ_FLAGS_EN
        carry_d     = carry_q;
        overflow_d  = overflow_q;
`endif

        if (consume) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.ALU_Sel == OP_MUL) begin
                        state_d  = MUL;
                        mcand_d  = {{WIDTH{1'b0}}, bus.A};
                        mplier_d = bus.B;
                        acc_d    = '0;
                        count_d  = '0;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                        carry_d     = alu_carry;
                        overflow_d  = alu_ovf;
`endif
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                count_d  = count_step;
                // The final partial product lands on the same edge that publishes the result.
                if (count_step == CNT_W'(WIDTH)) begin
                    state_d                 = IDLE;
                    {result_hi_d, result_d} = acc_step;
                    zero_d                  = (acc_step[WIDTH-1:0] == '0);
                    out_valid_d             = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    carry_d                 = |acc_step[2*WIDTH-1:WIDTH];
                    overflow_d              = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Result_Hi = result_hi_q;
    assign bus.Zero      = zero_q;

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.Carry    = carry_q;
    assign bus.Overflow = overflow_q;
    assign bus.Negative = result_q[WIDTH-1];
`else
    assign bus.Carry    = 1'b0;
    assign bus.Overflow = 1'b0;
    assign bus.Negative = 1'b0;
`endif

endmodule
